// File: rtl/ctrl_pipe.sv
// ctrl_pipe: stage-1 control decoder and stage-2 control register.
//
// Decodes a 5-bit opcode map, resolves branches combinationally in stage 1
// and registers an 11-bit control bundle into stage 2. A small FSM adds
// memory-latency stalls, a one-slot squash after taken branches and
// illegal-opcode handling.
//
// Parameters:
//   DATA_W  - width of the branch-test operand bt0
//   OPC_W   - opcode width (>= 5); bits above [4] must be zero when legal
//   MEM_LAT - extra wait cycles per memory op (0..15)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   in_valid in   instruction present on opcode/bt0
//   opcode   in   instruction opcode
//   bt0      in   branch-test register value
//   pc_sel   out  take branch/jump target this cycle (combinational)
//   stall    out  front end holds PC and instruction
//   flush    out  presented instruction is being squashed
//   ex_valid out  stage-2 bundle is live
//   ex_ctl   out  stage-2 control bundle
//     [0] reg_wr [1] mem_to_reg [2] mem_wr [3] taken [4] ra_en [5] imm_ld
//     [6] alu_r  [7] reg_ind    [8] jal    [9] lui   [10] illegal
module ctrl_pipe #(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] bt0,
  output logic              pc_sel,
  output logic              stall,
  output logic              flush,
  output logic              ex_valid,
  output logic [10:0]       ex_ctl
);

  localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [10:0] ex_ctl_q, ex_ctl_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [4:0] op;
  logic       upper_nz;

  assign op = opcode[4:0];

  // Any set bit above [4] makes the opcode illegal. The slice only exists
  // for wide opcodes, so it is built conditionally.
  if (OPC_W > 5) begin : g_upper
    assign upper_nz = |opcode[OPC_W-1:5];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  logic is_lw, is_sw, is_brp, is_brz, is_brn, is_j;
  logic is_lui, is_lli, is_lwr, is_swr, is_jal;
  logic alu_r, alu_i, ra_en;
  logic illegal, bt_neg, bt_zero, taken;
  logic dec_mem, dec_taken;
  logic [10:0] dec_ctl;

  assign is_lw  = (op == 5'd4);
  assign is_sw  = (op == 5'd5);
  assign is_brp = (op == 5'd6);
  assign is_brz = (op == 5'd7);
  assign is_brn = (op == 5'd8);
  assign is_j   = (op == 5'd9);
  assign is_lui = (op == 5'd14);
  assign is_lli = (op == 5'd15);
  assign is_lwr = (op == 5'd16);
  assign is_swr = (op == 5'd17);
  assign is_jal = (op == 5'd18);

  assign alu_r = ~op[4] & ~op[3] & ~op[2];
  // Opcodes 10..13 (ALU-immediate) share op3=1 with op1/op2 differing.
  assign alu_i = ~op[4] & op[3] & (op[1] ^ op[2]);
  assign ra_en = op[4] & op[1] & op[0];

  assign illegal = upper_nz | (op >= 5'd20);
  assign bt_neg  = bt0[DATA_W-1];
  assign bt_zero = (bt0 == '0);

  assign taken = (is_brp & ~bt_neg) | (is_brz & bt_zero) |
                 (is_brn & ~bt_zero) | is_j | is_jal;

  always_comb begin
    dec_ctl = 11'h000;
    if (illegal) begin
      dec_ctl[10] = 1'b1;
    end else begin
      dec_ctl[0] = is_lw | is_lui | is_lli | is_lwr | alu_r | alu_i;
      dec_ctl[1] = is_lw | is_lwr;
      dec_ctl[2] = is_sw | is_swr;
      dec_ctl[3] = taken;
      dec_ctl[4] = ra_en;
      dec_ctl[5] = is_lui | is_lli;
      dec_ctl[6] = alu_r;
      dec_ctl[7] = is_lwr | is_swr;
      dec_ctl[8] = is_jal;
      dec_ctl[9] = is_lui;
    end
  end

  assign dec_taken = ~illegal & taken;
  assign dec_mem   = ~illegal & (is_lw | is_lwr | is_sw | is_swr);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_ctl_d   = ex_ctl_q;
    pc_sel     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;

    case (state_q)
      RUN: begin
        if (in_valid) begin
          ex_valid_d = 1'b1;
          ex_ctl_d   = dec_ctl;
          // Branches and memory ops are disjoint opcodes, so at most one
          // of these transitions can fire.
          if (dec_taken) begin
            pc_sel  = 1'b1;
            state_d = FLUSH;
          end else if (dec_mem && (MEM_LAT > 0)) begin
            state_d = MEMWAIT;
            cnt_d   = MEM_LAT_C;
          end
        end else begin
          ex_valid_d = 1'b0;
          ex_ctl_d   = 11'h000;
        end
      end

      MEMWAIT: begin
        // Stage 2 keeps the memory op; inputs are held by the front end.
        stall = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      FLUSH: begin
        // The slot after a taken branch is discarded.
        flush      = 1'b1;
        ex_valid_d = 1'b0;
        ex_ctl_d   = 11'h000;
        state_d    = RUN;
      end

      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (rst) begin
      pc_sel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      ex_valid_q <= 1'b0;
      ex_ctl_q   <= 11'h000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_ctl_q   <= ex_ctl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ctl   = ex_ctl_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios followed by random stimulus,
// all checked against a cycle-level reference model through a scoreboard.
module tb_ctrl_pipe;

  localparam int DATA_W  = 32;
  localparam int OPC_W   = 6;
  localparam int MEM_LAT = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] bt0;
  logic              pc_sel;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [10:0]       ex_ctl;

  ctrl_pipe #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .opcode  (opcode),
    .bt0     (bt0),
    .pc_sel  (pc_sel),
    .stall   (stall),
    .flush   (flush),
    .ex_valid(ex_valid),
    .ex_ctl  (ex_ctl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  typedef struct packed {
    logic        pc_sel;
    logic        stall;
    logic        flush;
    logic        exv;
    logic [10:0] ctl;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state: cycles of stall still owed, a pending squash
  // slot, and the stage-2 contents.
  int          m_stall_left = 0;
  bit          m_flush_pend = 1'b0;
  bit          m_exv        = 1'b0;
  logic [10:0] m_exc        = 11'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Control bundle from the opcode table.
  function automatic logic [10:0] ref_ctl(input logic [OPC_W-1:0] opc, input logic [DATA_W-1:0] b);
    int o;
    logic [10:0] c;
    o = int'(opc);
    c = 11'h000;
    if (o >= 20) return 11'h400;
    c[0] = (o inside {[0:4], [10:16]});
    c[1] = (o == 4 || o == 16);
    c[2] = (o == 5 || o == 17);
    case (o)
      6:       c[3] = (b[DATA_W-1] == 1'b0);
      7:       c[3] = (b == 0);
      8:       c[3] = (b != 0);
      9, 18:   c[3] = 1'b1;
      default: c[3] = 1'b0;
    endcase
    c[4] = (o == 19);
    c[5] = (o == 14 || o == 15);
    c[6] = (o <= 3);
    c[7] = (o == 16 || o == 17);
    c[8] = (o == 18);
    c[9] = (o == 14);
    return c;
  endfunction

  function automatic bit ref_is_mem(input logic [OPC_W-1:0] opc);
    int o;
    o = int'(opc);
    return (o == 4 || o == 5 || o == 16 || o == 17);
  endfunction

  // Apply one cycle of inputs, record the expected outputs for this cycle,
  // then advance the model past the next edge.
  task automatic cyc(input bit r, input bit v, input int op, input logic [DATA_W-1:0] b);
    exp_t e;
    logic [10:0] c;
    @(posedge clk);
    #1;
    cyc_no++;
    rst      = r;
    in_valid = v;
    opcode   = OPC_W'(op);
    bt0      = b;
    c = ref_ctl(opcode, b);
    e.stall  = (m_stall_left > 0);
    e.flush  = m_flush_pend;
    e.pc_sel = !r && v && !e.stall && !e.flush && c[3];
    e.exv    = m_exv;
    e.ctl    = m_exc;
    e.cyc    = 32'(cyc_no);
    sb.push_back(e);
    if (r) begin
      m_stall_left = 0;
      m_flush_pend = 1'b0;
      m_exv        = 1'b0;
      m_exc        = 11'h000;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
    end else if (m_flush_pend) begin
      m_flush_pend = 1'b0;
      m_exv        = 1'b0;
      m_exc        = 11'h000;
    end else if (v) begin
      m_exv = 1'b1;
      m_exc = c;
      if (c[3]) m_flush_pend = 1'b1;
      else if (!c[10] && ref_is_mem(opcode) && MEM_LAT > 0) m_stall_left = MEM_LAT;
    end else begin
      m_exv = 1'b0;
      m_exc = 11'h000;
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_sel",   32'(pc_sel),   32'(e.pc_sel));
      chk("stall",    32'(stall),    32'(e.stall));
      chk("flush",    32'(flush),    32'(e.flush));
      chk("ex_valid", 32'(ex_valid), 32'(e.exv));
      chk("ex_ctl",   32'(ex_ctl),   32'(e.ctl));
    end
  end

  initial begin
    logic [DATA_W-1:0] rb;
    int ro;
    rst      = 1'b1;
    in_valid = 1'b0;
    opcode   = '0;
    bt0      = '0;

    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_ctl",   32'(ex_ctl),   0);
    chk("rst_stall",    32'(stall),    0);
    chk("rst_flush",    32'(flush),    0);

    // lui
    cyc(0, 1, 14, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("lui_ex_ctl",   32'(ex_ctl),   32'h221);
    chk("lui_ex_valid", 32'(ex_valid), 1);

    // lw with two wait cycles, then ALU-R
    cyc(0, 1, 4, 0);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    chk("lw_stall1", 32'(stall), 1);
    chk("lw_ctl1",   32'(ex_ctl), 32'h003);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    chk("lw_stall2", 32'(stall), 1);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    chk("lw_stall3", 32'(stall), 0);
    chk("lw_ctl3",   32'(ex_ctl), 32'h003);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("alu_ctl", 32'(ex_ctl), 32'h041);

    // brz taken, squash
    cyc(0, 1, 7, 0);
    @(negedge clk);
    chk("brz0_pc_sel", 32'(pc_sel), 1);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    chk("brz0_flush",  32'(flush),  1);
    chk("brz0_pc_sel_flush", 32'(pc_sel), 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("brz0_squash_valid", 32'(ex_valid), 0);

    // brz not taken
    cyc(0, 1, 7, 5);
    @(negedge clk);
    chk("brz5_pc_sel", 32'(pc_sel), 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("brz5_flush", 32'(flush), 0);

    // brp on negative, brn on nonzero, jal
    cyc(0, 1, 6, 32'h8000_0000);
    @(negedge clk);
    chk("brp_neg_pc_sel", 32'(pc_sel), 0);
    cyc(0, 1, 8, 1);
    @(negedge clk);
    chk("brn1_pc_sel", 32'(pc_sel), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 18, 0);
    @(negedge clk);
    chk("jal_pc_sel", 32'(pc_sel), 1);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("jal_ex_ctl", 32'(ex_ctl), 32'h108);

    // Illegal opcodes: out of range and nonzero upper bit (low bits = lw)
    cyc(0, 1, 25, 0);
    @(negedge clk);
    chk("ill25_pc_sel", 32'(pc_sel), 0);
    cyc(0, 1, 36, 0);
    @(negedge clk);
    chk("ill25_ex_ctl", 32'(ex_ctl), 32'h400);
    chk("ill25_ex_valid", 32'(ex_valid), 1);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("ill36_ex_ctl", 32'(ex_ctl), 32'h400);
    chk("ill36_stall",  32'(stall),  0);

    // Reset during the second wait cycle
    cyc(0, 1, 4, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 14, 0);
    @(negedge clk);
    chk("rstmw_stall",    32'(stall),    0);
    chk("rstmw_ex_valid", 32'(ex_valid), 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("rstmw_lui_ctl", 32'(ex_ctl), 32'h221);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'h8000_0000;
        2:       rb = 32'd1;
        default: rb = $urandom;
      endcase
      ro = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 23));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ro, rb);
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
